// File: rtl/packet_tx_buffer.sv
// Debug-port-loaded transmit buffer that streams frame bytes to an RMII byte transmitter.
// Optional build macro PKT_TX_PAD_EN pads short frames with zero bytes up to MIN_LEN.
module packet_tx_buffer #(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 60
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [2:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_wr,
  input  logic        dbg_rd,
  output logic [31:0] dbg_rdata,
  output logic [7:0]  txdata,
  output logic        txpacket,
  input  logic        txadvance,
  input  logic        txbusy,
  output logic        done
);

  localparam logic [ADDR_W:0]   DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   ONE       = (ADDR_W+1)'(1);
  localparam logic [31:0]       ID_WORD   = 32'h54584246;

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, DRAIN} state_t;

  state_t state, state_nxt;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        rdata;
  logic [ADDR_W-1:0] wrptr;
  logic [ADDR_W:0]   len, len_eff, len_wr, cnt, cnt_plus;
  logic [15:0]       sent_count;
  logic              done_sticky, fetch_pend;
  logic              idle, wr_data_en, wr_ptr_en, wr_len_en, start_ok;
  logic              rd_en, adv_step, last_adv, finish;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_bits;

  assign unused_bits = ^{dbg_rd, dbg_wdata[31:ADDR_W+1]};

  assign idle       = (state == IDLE);
  assign wr_data_en = dbg_wr && (dbg_addr == 3'd1) && idle;
  assign wr_ptr_en  = dbg_wr && (dbg_addr == 3'd2) && idle;
  assign wr_len_en  = dbg_wr && (dbg_addr == 3'd3) && idle;
  assign start_ok   = dbg_wr && (dbg_addr == 3'd4) && idle && (len != '0);
  assign len_wr     = (dbg_wdata[ADDR_W:0] > DEPTH_L) ? DEPTH_L : dbg_wdata[ADDR_W:0];
  assign cnt_plus   = cnt + ONE;

`ifdef PKT_TX_PAD_EN
  assign len_eff = (len < (ADDR_W+1)'(MIN_LEN)) ? (ADDR_W+1)'(MIN_LEN) : len;
`else
  assign len_eff = len;
`endif

  always_comb begin
    dbg_rdata = 32'd0;
    case (dbg_addr)
      3'd0:    dbg_rdata = ID_WORD;
      3'd1:    dbg_rdata = {30'd0, !idle, done_sticky};
      3'd2:    dbg_rdata = {{(32-ADDR_W){1'b0}}, wrptr};
      3'd3:    dbg_rdata = {{(31-ADDR_W){1'b0}}, len};
      3'd4:    dbg_rdata = {16'd0, sent_count};
      default: dbg_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (wr_data_en)
      mem[wrptr] <= dbg_wdata[7:0];
    if (rd_en)
      rdata <= mem[rd_addr];
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    adv_step  = 1'b0;
    last_adv  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          rd_en     = 1'b1;
          state_nxt = PREFETCH;
        end
      end
      PREFETCH: state_nxt = SEND;
      SEND: begin
        if (txadvance) begin
          if (cnt == len_eff - ONE) begin
            last_adv  = 1'b1;
            state_nxt = DRAIN;
          end else begin
            // padding bytes beyond len never touch the RAM
            adv_step = 1'b1;
            rd_en    = (cnt_plus < len);
            rd_addr  = cnt_plus[ADDR_W-1:0];
          end
        end
      end
      DRAIN: begin
        if (!txbusy) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wrptr       <= '0;
      len         <= '0;
      cnt         <= '0;
      sent_count  <= 16'd0;
      done_sticky <= 1'b0;
      done        <= 1'b0;
      txpacket    <= 1'b0;
      txdata      <= 8'h00;
      fetch_pend  <= 1'b0;
    end else begin
      done       <= finish;
      fetch_pend <= adv_step;
      if (wr_data_en && (wrptr != LAST_ADDR))
        wrptr <= wrptr + 1'b1;
      if (wr_ptr_en)
        wrptr <= dbg_wdata[ADDR_W-1:0];
      if (wr_len_en)
        len <= len_wr;
      if (start_ok) begin
        cnt         <= '0;
        done_sticky <= 1'b0;
      end
      if (state == PREFETCH) begin
        txdata   <= rdata;
        txpacket <= 1'b1;
      end
      if (adv_step)
        cnt <= cnt_plus;
      // the refetched byte lands in rdata one cycle after the advance
      if (fetch_pend) begin
`ifdef PKT_TX_PAD_EN
        txdata <= (cnt < len) ? rdata : 8'h00;
`else
        txdata <= rdata;
`endif
      end
      if (last_adv)
        txpacket <= 1'b0;
      if (finish) begin
        done_sticky <= 1'b1;
        sent_count  <= sent_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_packet_tx_buffer.sv
// Directed self-checking bench for packet_tx_buffer: debug register access, frame streaming,
// locking while busy, pointer saturation, length clamp, optional padding and mid-frame reset.
module tb_packet_tx_buffer;

  localparam int DEPTH = 2048;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_wr, dbg_rd;
  logic [31:0] dbg_rdata;
  logic [7:0]  txdata;
  logic        txpacket;
  logic        txadvance, txbusy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_mem [0:DEPTH-1];

  packet_tx_buffer #(.ADDR_W(11), .MIN_LEN(60)) dut (
    .clk50(clk50), .rst_n(rst_n),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wr(dbg_wr), .dbg_rd(dbg_rd),
    .dbg_rdata(dbg_rdata),
    .txdata(txdata), .txpacket(txpacket), .txadvance(txadvance), .txbusy(txbusy),
    .done(done)
  );

  always #10 clk50 = ~clk50;

  task automatic dbg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk50);
    dbg_addr = a; dbg_wdata = d; dbg_wr = 1'b1;
    @(negedge clk50);
    dbg_wr = 1'b0;
  endtask

  task automatic dbg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk50);
    dbg_addr = a; dbg_rd = 1'b1;
    #1 d = dbg_rdata;
    @(negedge clk50);
    dbg_rd = 1'b0;
  endtask

  task automatic stream_byte(input int i, input bit chk);
    repeat (3) @(negedge clk50);
    if (chk) begin
      n_checks++;
      if (txpacket !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL txpacket_byte%0d: got %b expected 1", i, txpacket);
      end
      n_checks++;
      if (txdata !== exp_mem[i]) begin
        n_fail++;
        $display("[TB] FAIL txdata_byte%0d: got %h expected %h", i, txdata, exp_mem[i]);
      end
    end
    txadvance = 1'b1;
    @(negedge clk50);
    txadvance = 1'b0;
  endtask

  task automatic stream_frame(input int n);
    for (int i = 0; i < n; i++) stream_byte(i, 1'b1);
    n_checks++;
    if (txpacket !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL txpacket_after_last: got %b expected 0", txpacket);
    end
  endtask

  task automatic finish_frame(input int exp_cnt);
    logic [31:0] d;
    repeat (2) @(negedge clk50);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_while_busy: got %b expected 0", done);
    end
    txbusy = 1'b0;
    @(negedge clk50);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL done_pulse: got %b expected 1", done);
    end
    @(negedge clk50);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_one_cycle: got %b expected 0", done);
    end
    txbusy = 1'b1;
    dbg_read(3'd4, d);
    n_checks++;
    if (d !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL sent_count: got %0d expected %0d", d, exp_cnt);
    end
    dbg_read(3'd1, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL status_after_done: got %h expected 1", d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    n_checks++;
    if ({txpacket, done, txdata} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b/%b/%h expected 0/0/00", txpacket, done, txdata);
    end
    rst_n = 1'b1;
    dbg_read(3'd0, d);
    n_checks++;
    if (d !== 32'h54584246) begin
      n_fail++;
      $display("[TB] FAIL reset_id: got %h expected 54584246", d);
    end
    for (int a = 1; a < 8; a++) begin
      dbg_read(a[2:0], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_reg%0d: got %h expected 0", a, d);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    bit seen = 0;
    dbg_write(3'd3, 32'd0);
    dbg_write(3'd4, 32'd0);
    repeat (10) begin
      @(negedge clk50);
      if (txpacket || done) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL zero_len_activity: got txpacket/done activity expected none");
    end
    dbg_read(3'd1, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL zero_len_status: got %h expected 0", d);
    end
    dbg_read(3'd4, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL zero_len_count: got %0d expected 0", d);
    end
  endtask

  task automatic test_basic_frame();
    dbg_write(3'd2, 32'd0);
    for (int i = 0; i < 64; i++) begin
      dbg_write(3'd1, i);
      exp_mem[i] = 8'(i);
    end
    dbg_write(3'd3, 32'd64);
    dbg_write(3'd4, 32'd0);
    stream_frame(64);
    finish_frame(1);
  endtask

  task automatic test_locked();
    logic [31:0] d;
    dbg_write(3'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_write(3'd1, 32'h10 + i);
      exp_mem[i] = 8'(8'h10 + i);
    end
    dbg_write(3'd3, 32'd8);
    dbg_write(3'd4, 32'd0);
    stream_byte(0, 1'b1);
    stream_byte(1, 1'b1);
    dbg_read(3'd1, d);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL busy_status: got %h expected 2", d);
    end
    dbg_write(3'd1, 32'hEE);
    dbg_write(3'd3, 32'd20);
    dbg_write(3'd2, 32'd100);
    dbg_write(3'd4, 32'd0);
    dbg_read(3'd2, d);
    n_checks++;
    if (d !== 32'd8) begin
      n_fail++;
      $display("[TB] FAIL locked_wrptr: got %0d expected 8", d);
    end
    dbg_read(3'd3, d);
    n_checks++;
    if (d !== 32'd8) begin
      n_fail++;
      $display("[TB] FAIL locked_len: got %0d expected 8", d);
    end
    for (int i = 2; i < 8; i++) stream_byte(i, 1'b1);
    n_checks++;
    if (txpacket !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL locked_frame_end: got %b expected 0", txpacket);
    end
    finish_frame(2);
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    dbg_write(3'd2, DEPTH - 2);
    dbg_write(3'd1, 32'h5A);
    dbg_write(3'd1, 32'h11);
    dbg_write(3'd1, 32'h22);
    dbg_write(3'd1, 32'h33);
    exp_mem[DEPTH-2] = 8'h5A;
    exp_mem[DEPTH-1] = 8'h33;
    dbg_read(3'd2, d);
    n_checks++;
    if (d !== DEPTH - 1) begin
      n_fail++;
      $display("[TB] FAIL wrptr_saturate: got %0d expected %0d", d, DEPTH - 1);
    end
    dbg_write(3'd3, 32'hFFF);
    dbg_read(3'd3, d);
    n_checks++;
    if (d !== DEPTH) begin
      n_fail++;
      $display("[TB] FAIL len_clamp: got %0d expected %0d", d, DEPTH);
    end
    dbg_write(3'd4, 32'd0);
    for (int i = 0; i < DEPTH; i++) stream_byte(i, (i < 64) || (i >= DEPTH - 2));
    n_checks++;
    if (txpacket !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_frame_end: got %b expected 0", txpacket);
    end
    finish_frame(3);
  endtask

  task automatic test_padding();
    int n;
    dbg_write(3'd2, 32'd0);
    for (int i = 0; i < 10; i++) begin
      dbg_write(3'd1, 32'hAA + i);
      exp_mem[i] = 8'(8'hAA + i);
    end
`ifdef PKT_TX_PAD_EN
    n = 60;
    for (int i = 10; i < 60; i++) exp_mem[i] = 8'h00;
`else
    n = 10;
`endif
    dbg_write(3'd3, 32'd10);
    dbg_write(3'd4, 32'd0);
    stream_frame(n);
    finish_frame(4);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    dbg_write(3'd3, 32'd20);
    dbg_write(3'd4, 32'd0);
    for (int i = 0; i < 5; i++) stream_byte(i, 1'b1);
    n_checks++;
    if (txpacket !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_txpacket: got %b expected 1", txpacket);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (txpacket !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_txpacket: got %b expected 0", txpacket);
    end
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    dbg_read(3'd0, d);
    n_checks++;
    if (d !== 32'h54584246) begin
      n_fail++;
      $display("[TB] FAIL post_reset_id: got %h expected 54584246", d);
    end
    dbg_read(3'd1, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_status: got %h expected 0", d);
    end
    txbusy = 1'b0;
    repeat (4) @(negedge clk50);
    n_checks++;
    if ({txpacket, done} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got %b%b expected 00", txpacket, done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dbg_addr = 3'd0; dbg_wdata = 32'd0; dbg_wr = 1'b0; dbg_rd = 1'b0;
    txadvance = 1'b0; txbusy = 1'b1;
    test_reset();
    test_zero_len();
    test_basic_frame();
    test_locked();
    test_saturate();
    test_padding();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
